// File: rtl/frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler_pkg
// Description : Shared state encodings and constants for the per-frame
//               game-update sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_scheduler_pkg;

  // One-hot sequencer states
  typedef enum logic [6:0] {
    ST_IDLE       = 7'b000_0001,
    ST_START      = 7'b000_0010,
    ST_WAIT_FRONT = 7'b000_0100,
    ST_ACK        = 7'b000_1000,
    ST_MOVE       = 7'b001_0000,
    ST_SPAWN      = 7'b010_0000,
    ST_DONE       = 7'b100_0000
  } state_e;

  // Tower locations shared with the front-finder; used as "no front yet"
  localparam logic [8:0] FRIENDLY_TOWER_LOC = 9'h1FF;
  localparam logic [8:0] ENEMY_TOWER_LOC    = 9'h000;

  localparam int DEFAULT_TIMEOUT   = 64;
  localparam int DEFAULT_NUM_SLOTS = 16;
  localparam int DEFAULT_OVR_W     = 8;

endpackage
`default_nettype wire

// File: rtl/frame_scheduler_request_tracker.sv
`default_nettype none
// ============================================================================
// Module      : frame_request_tracker
// Description : Buffers one frame tick that arrives while a frame is running
//               and counts further dropped ticks (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_request_tracker #(
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frameTick,
  input  logic             idleStart,
  input  logic             busy,
  output logic             pending,
  output logic [OVR_W-1:0] overrunCnt
);

  logic             pending_q, pending_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  // Next-state: buffer a busy tick, count extra ones, consume on idle start
  always_comb begin
    pending_d = pending_q;
    ovr_d     = ovr_q;
    if (busy && frameTick) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (ovr_q != {OVR_W{1'b1}}) begin
        ovr_d = ovr_q + 1'b1;
      end
    end else if (idleStart) begin
      // A start eats the buffered tick first; a coincident fresh tick refills it
      pending_d = pending_q & frameTick;
    end
  end

  // Tracker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pending    = pending_q;
  assign overrunCnt = ovr_q;

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler
// Description : Per-frame sequencer: front-finder handshake, movement sweep
//               over all unit slots, one spawn grant, end-of-frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int OVR_W     = DEFAULT_OVR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frameTick,
  input  logic                         frontDone,
  input  logic [8:0]                   friendlyFront,
  input  logic [8:0]                   enemyFront,
  output logic                         frontStart,
  output logic                         frontAck,
  output logic [8:0]                   latchedFriendlyFront,
  output logic [8:0]                   latchedEnemyFront,
  output logic [$clog2(NUM_SLOTS)-1:0] slotIdx,
  output logic                         moveEn,
  output logic                         spawnReq,
  input  logic                         spawnGnt,
  output logic                         busy,
  output logic                         frameDone,
  output logic                         timeoutErr,
  output logic [OVR_W-1:0]             overrunCnt
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [8:0]        lff_q, lff_d;
  logic [8:0]        lef_q, lef_d;
  logic              terr_q, terr_d;
  logic              pending;
  logic              idle_start;

  // Next-state, datapath updates and Moore output decode
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    slot_d     = slot_q;
    lff_d      = lff_q;
    lef_d      = lef_q;
    terr_d     = terr_q;
    frontStart = 1'b0;
    frontAck   = 1'b0;
    moveEn     = 1'b0;
    spawnReq   = 1'b0;
    frameDone  = 1'b0;
    busy       = 1'b1;
    idle_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy       = 1'b0;
        idle_start = frameTick | pending;
        if (idle_start) state_d = ST_START;
      end
      ST_START: begin
        frontStart = 1'b1;
        timer_d    = '0;
        state_d    = ST_WAIT_FRONT;
      end
      ST_WAIT_FRONT: begin
        // Done on the last allowed cycle still wins over the timeout
        if (frontDone) begin
          lff_d   = friendlyFront;
          lef_d   = enemyFront;
          state_d = ST_ACK;
        end else if (timer_q == TMR_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ACK: begin
        frontAck = 1'b1;
        slot_d   = '0;
        state_d  = ST_MOVE;
      end
      ST_MOVE: begin
        moveEn = 1'b1;
        // Stop on the last slot so slotIdx holds it after the sweep
        if (slot_q == SLOT_LAST) state_d = ST_SPAWN;
        else                     slot_d  = slot_q + 1'b1;
      end
      ST_SPAWN: begin
        spawnReq = 1'b1;
        if (spawnGnt) state_d = ST_DONE;
      end
      ST_DONE: begin
        frameDone = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      slot_q  <= '0;
      lff_q   <= FRIENDLY_TOWER_LOC;
      lef_q   <= ENEMY_TOWER_LOC;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      slot_q  <= slot_d;
      lff_q   <= lff_d;
      lef_q   <= lef_d;
      terr_q  <= terr_d;
    end
  end

  frame_request_tracker #(
    .OVR_W (OVR_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .frameTick  (frameTick),
    .idleStart  (idle_start),
    .busy       (busy),
    .pending    (pending),
    .overrunCnt (overrunCnt)
  );

  assign slotIdx              = slot_q;
  assign latchedFriendlyFront = lff_q;
  assign latchedEnemyFront    = lef_q;
  assign timeoutErr           = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_scheduler
// Description : Randomized self-checking bench for frame_scheduler with a
//               frame-level timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

  localparam int NS  = 16;
  localparam int TMO = 64;
  localparam int OW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frameTick, frontDone, spawnGnt;
  logic [8:0]    friendlyFront, enemyFront;
  logic          frontStart, frontAck, moveEn, spawnReq, busy, frameDone, timeoutErr;
  logic [8:0]    latchedFriendlyFront, latchedEnemyFront;
  logic [3:0]    slotIdx;
  logic [OW-1:0] overrunCnt;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit         m_pend;
  int         m_ovr;
  bit         m_terr;
  logic [8:0] m_lff, m_lef;
  int         m_slot;
  bit         tick_at [0:511];

  frame_scheduler #(.NUM_SLOTS(NS), .TIMEOUT(TMO), .OVR_W(OW)) dut (
    .clk(clk), .rst(rst), .frameTick(frameTick), .frontDone(frontDone),
    .friendlyFront(friendlyFront), .enemyFront(enemyFront),
    .frontStart(frontStart), .frontAck(frontAck),
    .latchedFriendlyFront(latchedFriendlyFront), .latchedEnemyFront(latchedEnemyFront),
    .slotIdx(slotIdx), .moveEn(moveEn), .spawnReq(spawnReq), .spawnGnt(spawnGnt),
    .busy(busy), .frameDone(frameDone), .timeoutErr(timeoutErr), .overrunCnt(overrunCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_ovr = 0; m_terr = 0; m_slot = 0;
    m_lff = 9'h1FF; m_lef = 9'h000;
  endfunction

  function automatic void clear_ticks();
    for (int i = 0; i < 512; i++) tick_at[i] = 0;
  endfunction

  // Cycle length of a frame from launch to the first IDLE cycle afterwards
  function automatic int frame_end(int w, int g, bit tmo);
    return tmo ? TMO + 2 : w + NS + g + 4;
  endfunction

  // Expected {frontStart, frontAck, moveEn, spawnReq, frameDone, busy} in cycle k
  function automatic logic [5:0] exp_strobes(int k, int w, int g, bit tmo);
    logic fs, fa, me, sr, fd, bz;
    fs = (k == 1);
    if (tmo) begin
      fa = 0; me = 0; sr = 0; fd = 0;
      bz = (k <= TMO + 1);
    end else begin
      fa = (k == w + 2);
      me = (k >= w + 3) && (k <= w + 2 + NS);
      sr = (k >= w + 3 + NS) && (k <= w + 2 + NS + g);
      fd = (k == w + 3 + NS + g);
      bz = (k <= w + 3 + NS + g);
    end
    return {fs, fa, me, sr, fd, bz};
  endfunction

  task automatic check_reset_outputs(string tag);
    check({tag, " strobes"}, {frontStart, frontAck, moveEn, spawnReq, frameDone, busy}, 6'd0);
    check({tag, " slot"}, slotIdx, 0);
    check({tag, " fronts"}, {latchedFriendlyFront, latchedEnemyFront}, {9'h1FF, 9'h000});
    check({tag, " terr"}, timeoutErr, 0);
    check({tag, " ovr"}, overrunCnt, 0);
  endtask

  // Launch one frame (by tick, or by the buffered tick) and follow it cycle by cycle
  task automatic run_frame(int w, int g, bit tmo, bit self_start,
                           logic [8:0] ff, logic [8:0] ef, int abort_k);
    int kend;
    kend = frame_end(w, g, tmo);
    frameTick = !self_start;
    @(posedge clk); #1;
    frameTick = 0;
    m_pend = 0;
    for (int k = 1; k <= kend; k++) begin
      if (!tmo && k == w + 2) begin m_lff = ff; m_lef = ef; end
      if (tmo && k == TMO + 2) m_terr = 1;
      if (!tmo && k >= w + 3 && k <= w + 2 + NS) m_slot = k - (w + 3);
      check($sformatf("strobes k=%0d", k),
            {frontStart, frontAck, moveEn, spawnReq, frameDone, busy}, exp_strobes(k, w, g, tmo));
      if (!tmo && k >= w + 3 && k <= w + 2 + NS)
        check($sformatf("slot k=%0d", k), slotIdx, m_slot);
      check($sformatf("fronts k=%0d", k), {latchedFriendlyFront, latchedEnemyFront}, {m_lff, m_lef});
      check($sformatf("terr k=%0d", k), timeoutErr, m_terr);
      if (k == abort_k) begin
        rst = 1; frontDone = 0; spawnGnt = 0;
        #2;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      if (k == kend) begin
        check("ovr_end", overrunCnt, m_ovr);
        check("slot_hold", slotIdx, m_slot);
        break;
      end
      frontDone     = !tmo && (k == w + 1);
      friendlyFront = frontDone ? ff : 9'($urandom);
      enemyFront    = frontDone ? ef : 9'($urandom);
      spawnGnt      = !tmo && (k == w + 2 + NS + g);
      frameTick     = tick_at[k];
      if (tick_at[k]) begin
        if (!m_pend) m_pend = 1;
        else if (m_ovr < 255) m_ovr++;
      end
      @(posedge clk); #1;
    end
    frameTick = 0; frontDone = 0; spawnGnt = 0;
  endtask

  initial begin
    int w, g, kend;
    bit tmo;
    rst = 1; frameTick = 0; frontDone = 0; spawnGnt = 0;
    friendlyFront = 0; enemyFront = 0;
    model_reset();
    clear_ticks();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Basic frame: Done on wait cycle 18, grant on 2nd spawn cycle
    run_frame(18, 2, 0, 0, 9'h120, 9'h045, 0);

    // Three ticks during one frame, then the buffered frame
    tick_at[5] = 1; tick_at[20] = 1; tick_at[30] = 1;
    run_frame(10, 1, 0, 0, 9'h0AA, 9'h155, 0);
    clear_ticks();
    check("pend_after_3", m_pend, 1);
    check("ovr_after_3", overrunCnt, 2);
    run_frame(4, 3, 0, 1, 9'h011, 9'h1E0, 0);

    // Done on the last allowed wait cycle beats the timeout
    run_frame(TMO, 1, 0, 0, 9'h033, 9'h0CC, 0);

    // No Done at all: timeout, no Ack, fronts unchanged
    run_frame(TMO, 1, 1, 0, 9'h000, 9'h000, 0);

    // Reset in the middle of the MOVE sweep at slot 7, then a full frame
    run_frame(5, 1, 0, 0, 9'h101, 9'h010, 5 + 3 + 7);
    run_frame(7, 2, 0, 0, 9'h0F0, 9'h00F, 0);

    // Random frames with random stray ticks
    for (int f = 0; f < 16; f++) begin
      tmo  = ($urandom_range(0, 5) == 0);
      w    = tmo ? TMO : $urandom_range(1, TMO);
      g    = $urandom_range(1, 6);
      kend = frame_end(w, g, tmo);
      clear_ticks();
      for (int k = 1; k < kend; k++) tick_at[k] = ($urandom_range(0, 11) == 0);
      run_frame(w, g, tmo, m_pend, 9'($urandom), 9'($urandom), 0);
    end

    // Saturation: 300 ticks inside one long frame
    clear_ticks();
    for (int k = 1; k <= 300; k++) tick_at[k] = 1;
    run_frame(3, 300, 0, m_pend, 9'h1C3, 9'h03C, 0);
    clear_ticks();
    check("ovr_saturated", overrunCnt, 255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
